// File: rtl/synth_pkg.sv
// Shared oscillator constants and the phase accumulator state encoding.
// PHASE_W_DEF must agree with the phase input width of the sine lookup.
package synth_pkg;

   localparam int PHASE_W_DEF = 21;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } acc_state_t;

endpackage

// File: rtl/phase_glide.sv
// Combinational glide step: moves the current increment toward the target
// by |diff|>>GLIDE_SHIFT (minimum 1), never overshooting. Built only with PHASE_ACC_GLIDE_EN.
`ifdef PHASE_ACC_GLIDE_EN
module phase_glide #(
   parameter int PHASE_W     = 21,
   parameter int GLIDE_SHIFT = 6
) (
   input  logic [PHASE_W-1:0] i_inc_cur,
   input  logic [PHASE_W-1:0] i_inc_target,
   output logic [PHASE_W-1:0] o_inc_next
);

   logic               w_up;
   logic [PHASE_W-1:0] w_mag;
   logic [PHASE_W-1:0] w_step;

   always_comb begin
      w_up   = (i_inc_target > i_inc_cur);
      w_mag  = w_up ? (i_inc_target - i_inc_cur) : (i_inc_cur - i_inc_target);
      w_step = w_mag >> GLIDE_SHIFT;
      // A zero step would stall short of the target; the shift keeps step <= |diff|.
      if ((w_step == '0) && (w_mag != '0)) begin
         w_step = {{(PHASE_W-1){1'b0}}, 1'b1};
      end
      o_inc_next = w_up ? (i_inc_cur + w_step) : (i_inc_cur - w_step);
   end

endmodule
`endif

// File: rtl/phase_acc.sv
// Phase accumulator for one oscillator voice: handshaked tuning word, hard sync,
// registered phase/valid/wrap. Optional pitch glide under PHASE_ACC_GLIDE_EN.
//
// state   | meaning
// IDLE    | phase held, no phase_valid pulses
// RUN     | phase advances by inc_cur on each sample_en
module phase_acc
   import synth_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF
`ifdef PHASE_ACC_GLIDE_EN
   , parameter int GLIDE_SHIFT = 6
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_en,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic               freq_valid,
   output logic               freq_ready,
   input  logic               sync,
   output logic [PHASE_W-1:0] phase,
   output logic               phase_valid,
   output logic               wrap
);

   acc_state_t         r_state;
   acc_state_t         w_state_next;
   logic [PHASE_W-1:0] r_inc_target;
   logic [PHASE_W-1:0] r_inc_cur;
   logic [PHASE_W-1:0] r_phase;
   logic               r_sync_pend;
   logic               r_ready;
   logic               r_phase_valid;
   logic               r_wrap;

   logic               w_accept;
   logic               w_word_zero;
   logic               w_update;
   logic               w_go_idle;
   logic               w_sync_eff;
   logic [PHASE_W:0]   w_sum;
   logic [PHASE_W-1:0] w_inc_step;

   assign w_accept    = freq_valid && r_ready;
   assign w_word_zero = (freq_word == '0);
   assign w_sync_eff  = sync || r_sync_pend;
   assign w_sum       = {1'b0, r_phase} + {1'b0, r_inc_cur};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept && !w_word_zero) w_state_next = ST_RUN;
         ST_RUN:  if (w_accept && w_word_zero)  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Accepting a zero word wins over a coincident tick so a stop never zeroes or moves phase.
   always_comb begin
      w_go_idle = (r_state == ST_RUN) && w_accept && w_word_zero;
      w_update  = (r_state == ST_RUN) && sample_en && !w_go_idle;
   end

`ifdef PHASE_ACC_GLIDE_EN
   phase_glide #(
      .PHASE_W     (PHASE_W),
      .GLIDE_SHIFT (GLIDE_SHIFT)
   ) u_glide (
      .i_inc_cur    (r_inc_cur),
      .i_inc_target (r_inc_target),
      .o_inc_next   (w_inc_step)
   );
`else
   assign w_inc_step = r_inc_cur;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready       <= 1'b1;
         r_inc_target  <= '0;
         r_inc_cur     <= '0;
         r_sync_pend   <= 1'b0;
         r_phase       <= '0;
         r_phase_valid <= 1'b0;
         r_wrap        <= 1'b0;
      end else begin
         r_ready       <= !w_accept;
         r_phase_valid <= w_update;
         r_wrap        <= w_update && !w_sync_eff && w_sum[PHASE_W];

         if (w_accept) r_inc_target <= freq_word;

`ifdef PHASE_ACC_GLIDE_EN
         if (w_accept && (w_word_zero || (r_state == ST_IDLE))) r_inc_cur <= freq_word;
         else if (w_update)                                     r_inc_cur <= w_inc_step;
`else
         if (w_accept) r_inc_cur <= freq_word;
`endif

         if (w_update) r_phase <= w_sync_eff ? '0 : w_sum[PHASE_W-1:0];

         if (w_go_idle || w_update) r_sync_pend <= 1'b0;
         else if (sync)             r_sync_pend <= 1'b1;
      end
   end

   assign freq_ready  = r_ready;
   assign phase       = r_phase;
   assign phase_valid = r_phase_valid;
   assign wrap        = r_wrap;

endmodule

// File: tb/tb_phase_acc.sv
// Directed bench for phase_acc (default build, no glide): handshake, accumulation,
// wrap, sync, stop-to-idle and asynchronous reset.
module tb_phase_acc;

   localparam int W = 21;

   logic         clk = 1'b0;
   logic         rst;
   logic         sample_en;
   logic [W-1:0] freq_word;
   logic         freq_valid;
   logic         freq_ready;
   logic         sync;
   logic [W-1:0] phase;
   logic         phase_valid;
   logic         wrap;

   int n_total = 0;
   int n_bad   = 0;

   phase_acc dut (
      .clk         (clk),
      .rst         (rst),
      .sample_en   (sample_en),
      .freq_word   (freq_word),
      .freq_valid  (freq_valid),
      .freq_ready  (freq_ready),
      .sync        (sync),
      .phase       (phase),
      .phase_valid (phase_valid),
      .wrap        (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      rst = 1'b1; sample_en = 1'b0; freq_word = '0; freq_valid = 1'b0; sync = 1'b0;
      cyc(); cyc();
      chk("rst_phase", 32'(phase), 32'h0);
      chk("rst_valid", 32'(phase_valid), 32'h0);
      chk("rst_wrap",  32'(wrap), 32'h0);
      chk("rst_ready", 32'(freq_ready), 32'h1);
      rst = 1'b0;

      // IDLE: ticks do nothing
      sample_en = 1'b1;
      cyc(); cyc();
      chk("idle_valid", 32'(phase_valid), 32'h0);
      chk("idle_phase", 32'(phase), 32'h0);
      sample_en = 1'b0;

      // accept 1, then count 1,2,3,...
      freq_word = 21'd1; freq_valid = 1'b1;
      cyc();
      freq_valid = 1'b0;
      chk("ready_low_after_acc", 32'(freq_ready), 32'h0);
      sample_en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk($sformatf("count_phase%0d", i), 32'(phase), 32'(i));
         chk($sformatf("count_valid%0d", i), 32'(phase_valid), 32'h1);
         chk($sformatf("count_wrap%0d", i), 32'(wrap), 32'h0);
      end
      chk("ready_back", 32'(freq_ready), 32'h1);

      // sync pulse without tick, tick three cycles later
      sample_en = 1'b0; sync = 1'b1;
      cyc();
      sync = 1'b0;
      cyc();
      chk("sync_hold_phase", 32'(phase), 32'd5);
      chk("sync_hold_valid", 32'(phase_valid), 32'h0);
      cyc();
      sample_en = 1'b1;
      cyc();
      sample_en = 1'b0;
      chk("sync_phase", 32'(phase), 32'h0);
      chk("sync_valid", 32'(phase_valid), 32'h1);
      chk("sync_wrap",  32'(wrap), 32'h0);
      sample_en = 1'b1;
      cyc();
      sample_en = 1'b0;
      chk("post_sync_phase", 32'(phase), 32'd1);

      // sync together with new word, then wrap sequence
      freq_word = 21'h100000; freq_valid = 1'b1; sync = 1'b1;
      cyc();
      freq_valid = 1'b0; sync = 1'b0; sample_en = 1'b1;
      cyc();
      chk("wr_sync_phase", 32'(phase), 32'h0);
      cyc();
      chk("wr_phase1", 32'(phase), 32'h100000);
      chk("wr_wrap1",  32'(wrap), 32'h0);
      cyc();
      chk("wr_phase2", 32'(phase), 32'h000000);
      chk("wr_wrap2",  32'(wrap), 32'h1);
      chk("wr_valid2", 32'(phase_valid), 32'h1);
      cyc();
      chk("wr_phase3", 32'(phase), 32'h100000);
      chk("wr_wrap3",  32'(wrap), 32'h0);

      // sync coincident with tick applies to that tick
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      chk("sync_same_phase", 32'(phase), 32'h0);
      chk("sync_same_wrap",  32'(wrap), 32'h0);
      cyc();
      chk("sync_same_next", 32'(phase), 32'h100000);

      // stop with zero word: phase freezes, no valid
      sample_en = 1'b0; freq_word = '0; freq_valid = 1'b1;
      cyc();
      freq_valid = 1'b0; sample_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("stop_phase%0d", i), 32'(phase), 32'h100000);
         chk($sformatf("stop_valid%0d", i), 32'(phase_valid), 32'h0);
      end
      sample_en = 1'b0;

      // freq_valid held four cycles: accepts in cycles 0 and 2
      acc = 0;
      freq_word = 21'd3; freq_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("hs_ready%0d", i), 32'(freq_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
         if (freq_ready) acc++;
         cyc();
      end
      freq_valid = 1'b0;
      chk("hs_accepts", 32'(acc), 32'd2);

      // runs at inc 3 from the frozen phase
      sample_en = 1'b1;
      cyc();
      chk("inc3_a", 32'(phase), 32'h100003);
      cyc();
      chk("inc3_b", 32'(phase), 32'h100006);

      // acceptance coincident with a tick: that tick uses the old increment
      freq_word = 21'd5; freq_valid = 1'b1;
      cyc();
      freq_valid = 1'b0;
      chk("old_inc", 32'(phase), 32'h100009);
      cyc();
      chk("new_inc", 32'(phase), 32'h10000E);

      // asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      chk("arst_phase", 32'(phase), 32'h0);
      chk("arst_valid", 32'(phase_valid), 32'h0);
      chk("arst_ready", 32'(freq_ready), 32'h1);
      cyc();
      rst = 1'b0;
      cyc(); cyc();
      chk("arst_idle_valid", 32'(phase_valid), 32'h0);
      chk("arst_idle_phase", 32'(phase), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
